// File: rtl/bit_serial_adder.sv
// Bit-serial N-bit adder: one full adder plus a carry flop, LSB first, one bit per clock.
// Result, carry-out and signed overflow are registered and held until the next accepted start.

module full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);

   always_comb begin
      sum  = a ^ b ^ cin;
      cout = (a & b) | (cin & (a ^ b));
   end

endmodule

module bit_serial_adder #(
   parameter int unsigned N = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         cin,
   output logic         busy,
   output logic         done,
   output logic [N-1:0] sum,
   output logic         cout,
   output logic         ovf
);

   localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t         state;
   state_t         state_next;
   logic [N-1:0]   a_sr;
   logic [N-1:0]   a_sr_next;
   logic [N-1:0]   b_sr;
   logic [N-1:0]   b_sr_next;
   logic [N-1:0]   sum_next;
   logic [CW-1:0]  cnt;
   logic [CW-1:0]  cnt_next;
   logic           carry;
   logic           carry_next;
   logic           cout_next;
   logic           ovf_next;
   logic           busy_next;
   logic           done_next;
   logic           accept;
   logic           last_bit;
   logic           fa_sum;
   logic           fa_cout;

   full_adder u_fa (
      .a    (a_sr[0]),
      .b    (b_sr[0]),
      .cin  (carry),
      .sum  (fa_sum),
      .cout (fa_cout)
   );

   // State and datapath registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         a_sr  <= '0;
         b_sr  <= '0;
         carry <= 1'b0;
         cnt   <= '0;
         sum   <= '0;
         cout  <= 1'b0;
         ovf   <= 1'b0;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         state <= state_next;
         a_sr  <= a_sr_next;
         b_sr  <= b_sr_next;
         carry <= carry_next;
         cnt   <= cnt_next;
         sum   <= sum_next;
         cout  <= cout_next;
         ovf   <= ovf_next;
         busy  <= busy_next;
         done  <= done_next;
      end
   end

   // Next-state and next-datapath logic; busy/done are registered from the next state
   always_comb begin
      state_next = state;
      a_sr_next  = a_sr;
      b_sr_next  = b_sr;
      carry_next = carry;
      cnt_next   = cnt;
      sum_next   = sum;
      cout_next  = cout;
      ovf_next   = ovf;
      accept     = 1'b0;
      last_bit   = (cnt == CW'(N - 1));

      case (state)
         IDLE, DONE: begin
            accept     = start;
            state_next = IDLE;
            if (start) begin
               state_next = RUN;
               a_sr_next  = a;
               b_sr_next  = b;
               carry_next = cin;
               cnt_next   = '0;
               sum_next   = '0;
               cout_next  = 1'b0;
               ovf_next   = 1'b0;
            end
         end
         RUN: begin
            // Sum bits enter at the MSB so bit 0 lands at sum[0] after N shifts
            sum_next   = (sum >> 1) | (N'(fa_sum) << (N - 1));
            a_sr_next  = a_sr >> 1;
            b_sr_next  = b_sr >> 1;
            carry_next = fa_cout;
            cnt_next   = cnt + CW'(1);
            if (last_bit) begin
               cout_next  = fa_cout;
               ovf_next   = carry ^ fa_cout;
               state_next = DONE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase

      busy_next = (state_next == RUN);
      done_next = (state_next == DONE);
   end

endmodule

// File: tb/tb_bit_serial_adder.sv
// Directed bench for bit_serial_adder at N=8 and N=1 with a result scoreboard.
// Expected results are computed arithmetically when an operation is launched.

module tb_bit_serial_adder;

   typedef struct {
      logic [7:0] sum;
      logic       cout;
      logic       ovf;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       start8;
   logic [7:0] a8;
   logic [7:0] b8;
   logic       cin8;
   logic       busy8;
   logic       done8;
   logic [7:0] sum8;
   logic       cout8;
   logic       ovf8;
   logic       start1;
   logic [0:0] a1;
   logic [0:0] b1;
   logic       cin1;
   logic       busy1;
   logic       done1;
   logic [0:0] sum1;
   logic       cout1;
   logic       ovf1;

   int   tests = 0;
   int   fails = 0;
   exp_t sb[$];

   always #5 clk = ~clk;

   bit_serial_adder #(.N(8)) dut8 (
      .clk   (clk),
      .rst   (rst),
      .start (start8),
      .a     (a8),
      .b     (b8),
      .cin   (cin8),
      .busy  (busy8),
      .done  (done8),
      .sum   (sum8),
      .cout  (cout8),
      .ovf   (ovf8)
   );

   bit_serial_adder #(.N(1)) dut1 (
      .clk   (clk),
      .rst   (rst),
      .start (start1),
      .a     (a1),
      .b     (b1),
      .cin   (cin1),
      .busy  (busy1),
      .done  (done1),
      .sum   (sum1),
      .cout  (cout1),
      .ovf   (ovf1)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Launch one addition on the selected DUT and check its timing and result.
   task automatic op(input bit sel1, input logic [7:0] ta, input logic [7:0] tb_,
                     input logic tcin, input bit keep, input string tag);
      exp_t       e;
      exp_t       got;
      logic [8:0] full;
      int         cyc;
      int         busy_cnt;
      int         w;
      bit         seen;
      w = sel1 ? 1 : 8;
      if (sel1) begin
         full   = 9'(ta[0]) + 9'(tb_[0]) + 9'(tcin);
         e.sum  = {7'd0, full[0]};
         e.cout = full[1];
         e.ovf  = (ta[0] == tb_[0]) && (full[0] != ta[0]);
         start1 = 1'b1;
         a1     = ta[0];
         b1     = tb_[0];
         cin1   = tcin;
      end else begin
         full   = 9'(ta) + 9'(tb_) + 9'(tcin);
         e.sum  = full[7:0];
         e.cout = full[8];
         e.ovf  = (ta[7] == tb_[7]) && (full[7] != ta[7]);
         start8 = 1'b1;
         a8     = ta;
         b8     = tb_;
         cin8   = tcin;
      end
      sb.push_back(e);
      @(posedge clk);
      #1;
      if (!keep) begin
         start8 = 1'b0;
         start1 = 1'b0;
      end
      // Operands changed after acceptance must not matter
      a8   = ~ta;
      b8   = ~tb_;
      cin8 = ~tcin;
      a1   = ~ta[0];
      b1   = ~tb_[0];
      cin1 = ~tcin;
      seen     = 1'b0;
      busy_cnt = 0;
      for (cyc = 1; cyc <= 40; cyc++) begin
         @(negedge clk);
         if (sel1 ? done1 : done8) begin
            seen = 1'b1;
            break;
         end
         if (sel1 ? busy1 : busy8) busy_cnt++;
      end
      check({tag, "_done_seen"}, 64'(seen), 64'd1);
      check({tag, "_latency"}, 64'(cyc), 64'(w + 1));
      check({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(w));
      check({tag, "_busy_at_done"}, 64'(sel1 ? busy1 : busy8), 64'd0);
      got = sb.pop_front();
      check({tag, "_sum"}, sel1 ? 64'(sum1) : 64'(sum8), 64'(got.sum));
      check({tag, "_cout"}, 64'(sel1 ? cout1 : cout8), 64'(got.cout));
      check({tag, "_ovf"}, 64'(sel1 ? ovf1 : ovf8), 64'(got.ovf));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      int dones;
      rst    = 1'b1;
      start8 = 1'b1;
      a8     = 8'h12;
      b8     = 8'h34;
      cin8   = 1'b1;
      start1 = 1'b1;
      a1     = 1'b1;
      b1     = 1'b1;
      cin1   = 1'b1;

      // Reset held two cycles with start asserted
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_busy", 64'(busy8), 64'd0);
      check("rst_done", 64'(done8), 64'd0);
      check("rst_sum", 64'(sum8), 64'd0);
      check("rst_cout", 64'(cout8), 64'd0);
      check("rst_ovf", 64'(ovf8), 64'd0);
      check("rst_busy_n1", 64'(busy1), 64'd0);
      rst    = 1'b0;
      start8 = 1'b0;
      start1 = 1'b0;
      @(posedge clk);
      #1;
      check("post_rst_idle", 64'(busy8), 64'd0);

      // Basic addition plus result hold afterwards
      op(1'b0, 8'h3C, 8'h05, 1'b0, 1'b0, "add_3c_05");
      repeat (3) @(negedge clk);
      check("hold_sum", 64'(sum8), 64'h41);
      check("hold_done_low", 64'(done8), 64'd0);
      check("hold_busy_low", 64'(busy8), 64'd0);

      op(1'b0, 8'hFF, 8'h01, 1'b0, 1'b0, "add_ff_01");
      @(negedge clk);
      op(1'b0, 8'h7F, 8'h00, 1'b1, 1'b0, "add_7f_00_c1");
      @(negedge clk);

      // Back-to-back with start held high throughout
      for (int i = 0; i < 3; i++) op(1'b0, 8'h80, 8'h80, 1'b1, 1'b1, $sformatf("b2b%0d", i));
      start8 = 1'b0;
      @(negedge clk);
      @(negedge clk);

      // Reset mid-run aborts the operation
      start8 = 1'b1;
      a8     = 8'hAA;
      b8     = 8'h55;
      cin8   = 1'b0;
      @(posedge clk);
      #1;
      start8 = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("abort_busy", 64'(busy8), 64'd0);
      check("abort_done", 64'(done8), 64'd0);
      check("abort_sum", 64'(sum8), 64'd0);
      check("abort_cout", 64'(cout8), 64'd0);
      check("abort_ovf", 64'(ovf8), 64'd0);
      dones = 0;
      repeat (12) begin
         @(negedge clk);
         if (done8) dones++;
      end
      check("abort_no_done", 64'(dones), 64'd0);
      @(posedge clk);
      #1;
      op(1'b0, 8'hAA, 8'h55, 1'b0, 1'b0, "after_abort");
      @(negedge clk);

      // N=1: every combination of a, b, cin
      for (int i = 0; i < 8; i++) begin
         logic [2:0] v;
         v = 3'(i);
         op(1'b1, {7'd0, v[2]}, {7'd0, v[1]}, v[0], 1'b0, $sformatf("n1_%0d", i));
         @(negedge clk);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
